// File: rtl/model_sdram_burst_ctrl.sv
// Behavioural SDRAM burst model: word-addressed backing array, configurable read latency,
// burst length and write-ack latency, byte-enabled writes, sticky protocol-error flag.
// Optional feature: define SDRAM_MODEL_CRIT_WORD_FIRST_EN for critical-word-first beat order.
module model_sdram_burst_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4,
   parameter int READ_LAT  = 5,
   parameter int WACK_LAT  = 5,
   parameter int MEM_WORDS = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     addr,
   input  logic                  mr,
   input  logic                  mw,
   input  logic [DATA_W-1:0]     datain,
   input  logic [DATA_W/8-1:0]   wbe,
   output logic [DATA_W-1:0]     dataout,
   output logic                  rvalid,
   output logic                  gready,
   output logic                  busy,
   output logic                  err
);

   localparam int BYTES   = DATA_W / 8;
   localparam int OFF_W   = $clog2(BYTES);
   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int BL_W    = $clog2(BURST_LEN);
   localparam int BEAT_W  = BL_W + 1;
   localparam int MAX_LAT = (READ_LAT > WACK_LAT) ? READ_LAT : WACK_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_BURST,
      WR_ACK
   } state_t;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [BEAT_W-1:0] beat, beat_n;
   logic [IDX_W-1:0]  base, base_n;
   logic [BL_W-1:0]   start, start_n;
   logic [DATA_W-1:0] dout_n;
   logic              rvalid_n, gready_n, err_n;
   logic              we;
   logic [IDX_W-1:0]  waddr, raddr;
   logic [IDX_W-1:0]  req_idx;
   logic [BL_W-1:0]   req_start;
   logic              unused_bits;

   // Beat k lands on the aligned burst, offset wrapped modulo BURST_LEN from start.
   function automatic logic [IDX_W-1:0] beat_word(input logic [IDX_W-1:0] b,
                                                  input logic [BL_W-1:0]  s,
                                                  input logic [BEAT_W-1:0] k);
      logic [BL_W-1:0] off;
      off = s + k[BL_W-1:0];
      return {b[IDX_W-1:BL_W], off};
   endfunction

   assign req_idx = addr[OFF_W +: IDX_W];
`ifdef SDRAM_MODEL_CRIT_WORD_FIRST_EN
   assign req_start = req_idx[BL_W-1:0];
`else
   assign req_start = '0;
`endif
   assign unused_bits = ^{addr, req_idx};

   assign busy = (state != IDLE);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      beat_n   = beat;
      base_n   = base;
      start_n  = start;
      dout_n   = '0;
      rvalid_n = 1'b0;
      gready_n = 1'b0;
      err_n    = err;
      we       = 1'b0;
      waddr    = beat_word(base, start, beat);
      raddr    = beat_word(base, start, beat);
      case (state)
         IDLE: begin
            if (mr && mw) begin
               err_n = 1'b1;
            end else if (mr) begin
               base_n  = req_idx;
               start_n = req_start;
               cnt_n   = CNT_W'(READ_LAT - 1);
               state_n = RD_WAIT;
            end else if (mw) begin
               // Beat 0 is written straight from the live address before it is latched.
               base_n  = req_idx;
               start_n = req_start;
               we      = 1'b1;
               waddr   = beat_word(req_idx, req_start, '0);
               beat_n  = BEAT_W'(1);
               if (BURST_LEN == 1) begin
                  cnt_n   = CNT_W'(WACK_LAT - 1);
                  beat_n  = '0;
                  state_n = WR_ACK;
               end else begin
                  state_n = WR_BURST;
               end
            end
         end
         RD_WAIT: begin
            if (cnt == '0) begin
               raddr    = beat_word(base, start, '0);
               dout_n   = mem[raddr];
               rvalid_n = 1'b1;
               gready_n = 1'b1;
               beat_n   = BEAT_W'(1);
               state_n  = RD_BURST;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         RD_BURST: begin
            if (beat == BEAT_W'(BURST_LEN)) begin
               beat_n  = '0;
               state_n = IDLE;
            end else begin
               dout_n   = mem[raddr];
               rvalid_n = 1'b1;
               beat_n   = beat + BEAT_W'(1);
            end
         end
         WR_BURST: begin
            we     = 1'b1;
            beat_n = beat + BEAT_W'(1);
            if (beat == BEAT_W'(BURST_LEN - 1)) begin
               cnt_n   = CNT_W'(WACK_LAT - 1);
               beat_n  = '0;
               state_n = WR_ACK;
            end
         end
         WR_ACK: begin
            if (gready) begin
               state_n = IDLE;
            end else if (cnt == '0) begin
               gready_n = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if ((state != IDLE) && (mr || mw)) err_n = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         beat    <= '0;
         base    <= '0;
         start   <= '0;
         dataout <= '0;
         rvalid  <= 1'b0;
         gready  <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         beat    <= beat_n;
         base    <= base_n;
         start   <= start_n;
         dataout <= dout_n;
         rvalid  <= rvalid_n;
         gready  <= gready_n;
         err     <= err_n;
      end
   end

   // Backing store is never cleared; a reset edge suppresses the beat it coincides with.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (wbe[b]) mem[waddr][8*b +: 8] <= datain[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_model_sdram_burst_ctrl.sv
// Bench for model_sdram_burst_ctrl: a default instance and a BURST_LEN=8/READ_LAT=2/WACK_LAT=1
// instance, checked every cycle against a cycle-indexed expectation model plus literal checks.
module tb_model_sdram_burst_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i  [2];
   logic [31:0] addr_i [2];
   logic        mr_i   [2];
   logic        mw_i   [2];
   logic [31:0] din_i  [2];
   logic [3:0]  wbe_i  [2];
   logic [31:0] dout_o [2];
   logic        rv_o   [2];
   logic        gr_o   [2];
   logic        busy_o [2];
   logic        err_o  [2];

   model_sdram_burst_ctrl u_dut0 (
      .clk(clk), .rst(rst_i[0]), .addr(addr_i[0]), .mr(mr_i[0]), .mw(mw_i[0]),
      .datain(din_i[0]), .wbe(wbe_i[0]), .dataout(dout_o[0]), .rvalid(rv_o[0]),
      .gready(gr_o[0]), .busy(busy_o[0]), .err(err_o[0])
   );

   model_sdram_burst_ctrl #(.BURST_LEN(8), .READ_LAT(2), .WACK_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst_i[1]), .addr(addr_i[1]), .mr(mr_i[1]), .mw(mw_i[1]),
      .datain(din_i[1]), .wbe(wbe_i[1]), .dataout(dout_o[1]), .rvalid(rv_o[1]),
      .gready(gr_o[1]), .busy(busy_o[1]), .err(err_o[1])
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   bit          exp_busy [int];
   bit          exp_gr   [int];
   bit          exp_rv   [int];
   logic [31:0] exp_d    [int];
   logic [31:0] mmem     [int];
   int          err_set  [2];
   int          gr_cyc   [2];
   int          ref_edge [2];
   logic [31:0] wd [8];
   logic [3:0]  wb [8];
   logic [31:0] cap0 [$];
   logic [31:0] cap1 [$];

   function automatic int bl(input int w); return (w == 1) ? 8 : 4; endfunction
   function automatic int rl(input int w); return (w == 1) ? 2 : 5; endfunction
   function automatic int wl(input int w); return (w == 1) ? 1 : 5; endfunction
   function automatic int key(input int w, input int c); return w * 1000000 + c; endfunction

   function automatic int word_of(input int w, input int a, input int k);
      int idx, base, st;
      idx  = (a / 4) % 4096;
      base = idx - (idx % bl(w));
`ifdef SDRAM_MODEL_CRIT_WORD_FIRST_EN
      st = idx % bl(w);
`else
      st = 0;
`endif
      return base + ((st + k) % bl(w));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual %h required %h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : cmp
      int k;
      bit eb, eg, ev, ee;
      logic [31:0] ed;
      if (chk_en) begin
         for (int w = 0; w < 2; w++) begin
            k  = key(w, cyc);
            eb = exp_busy.exists(k);
            eg = exp_gr.exists(k);
            ev = exp_rv.exists(k);
            ed = ev ? exp_d[k] : 32'h0;
            ee = (err_set[w] >= 0) && (cyc >= err_set[w]);
            chk($sformatf("dut%0d_busy", w),    32'(busy_o[w]), 32'(eb));
            chk($sformatf("dut%0d_gready", w),  32'(gr_o[w]),   32'(eg));
            chk($sformatf("dut%0d_rvalid", w),  32'(rv_o[w]),   32'(ev));
            chk($sformatf("dut%0d_dataout", w), dout_o[w],      ed);
            chk($sformatf("dut%0d_err", w),     32'(err_o[w]),  32'(ee));
            if (rv_o[w]) begin
               if (w == 0) cap0.push_back(dout_o[w]);
               else        cap1.push_back(dout_o[w]);
            end
            if (gr_o[w]) gr_cyc[w] = cyc;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_from(input int w, input int c);
      int kk;
      for (int t = c; t < c + 64; t++) begin
         kk = key(w, t);
         if (exp_busy.exists(kk)) exp_busy.delete(kk);
         if (exp_gr.exists(kk))   exp_gr.delete(kk);
         if (exp_rv.exists(kk))   exp_rv.delete(kk);
         if (exp_d.exists(kk))    exp_d.delete(kk);
      end
   endtask

   task automatic do_write(input int w, input int a, input int rst_beat);
      int e0, last, wi;
      logic [31:0] m;
      e0   = cyc + 1;
      last = e0 + bl(w) - 1 + wl(w);
      ref_edge[w] = e0 + bl(w) - 1;
      for (int t = e0; t <= last; t++) exp_busy[key(w, t)] = 1'b1;
      exp_gr[key(w, last)] = 1'b1;
      for (int k = 0; k < bl(w); k++) begin
         mw_i[w]   = (k == 0);
         addr_i[w] = a;
         din_i[w]  = wd[k];
         wbe_i[w]  = wb[k];
         if (k == rst_beat) begin
            rst_i[w] = 1'b1;
            clear_from(w, cyc + 1);
            err_set[w] = -1;
            tick();
            rst_i[w] = 1'b0;
            mw_i[w]  = 1'b0;
            wbe_i[w] = 4'h0;
            return;
         end
         wi = key(w, word_of(w, a, k));
         m  = mmem.exists(wi) ? mmem[wi] : 32'hx;
         for (int b = 0; b < 4; b++) if (wb[k][b]) m[8*b +: 8] = wd[k][8*b +: 8];
         mmem[wi] = m;
         tick();
         mw_i[w] = 1'b0;
      end
      wbe_i[w] = 4'h0;
      while (cyc < last + 1) tick();
   endtask

   task automatic do_read(input int w, input int a, input int inj);
      int e0, first, last, wi;
      e0    = cyc + 1;
      first = e0 + rl(w);
      last  = first + bl(w) - 1;
      ref_edge[w] = e0;
      for (int t = e0; t <= last; t++) exp_busy[key(w, t)] = 1'b1;
      exp_gr[key(w, first)] = 1'b1;
      for (int k = 0; k < bl(w); k++) begin
         wi = key(w, word_of(w, a, k));
         exp_rv[key(w, first + k)] = 1'b1;
         exp_d[key(w, first + k)]  = mmem.exists(wi) ? mmem[wi] : 32'hx;
      end
      if (w == 0) cap0.delete(); else cap1.delete();
      mr_i[w]   = 1'b1;
      addr_i[w] = a;
      tick();
      mr_i[w] = 1'b0;
      while (cyc < last + 1) begin
         if (inj > 0 && cyc == e0 - 1 + inj) begin
            mr_i[w]    = 1'b1;
            addr_i[w]  = 32'h80;
            err_set[w] = cyc + 1;
         end
         tick();
         mr_i[w] = 1'b0;
      end
   endtask

   task automatic do_both(input int w, input int a);
      mr_i[w]    = 1'b1;
      mw_i[w]    = 1'b1;
      addr_i[w]  = a;
      din_i[w]   = 32'hDEAD_BEEF;
      wbe_i[w]   = 4'hF;
      err_set[w] = cyc + 1;
      tick();
      mr_i[w]  = 1'b0;
      mw_i[w]  = 1'b0;
      wbe_i[w] = 4'h0;
      repeat (4) tick();
   endtask

   initial begin
      for (int w = 0; w < 2; w++) begin
         rst_i[w] = 1'b1; addr_i[w] = '0; mr_i[w] = 1'b0; mw_i[w] = 1'b0;
         din_i[w] = '0; wbe_i[w] = '0; err_set[w] = -1; gr_cyc[w] = -1000; ref_edge[w] = 0;
      end
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      tick();
      rst_i[0] = 1'b0;
      rst_i[1] = 1'b0;
      tick();

      // Basic write then read at 0x40
      for (int k = 0; k < 8; k++) begin wd[k] = 32'h11 * (k + 1); wb[k] = 4'hF; end
      do_write(0, 32'h40, -1);
      chk("wr_ack_gap", gr_cyc[0] - ref_edge[0], 5);
      do_read(0, 32'h40, 0);
      chk("rd_first_beat_lat", gr_cyc[0] - ref_edge[0], 5);
      chk("rd40_count", cap0.size(), 4);
      chk("rd40_b0", cap0[0], 32'h11);
      chk("rd40_b1", cap0[1], 32'h22);
      chk("rd40_b2", cap0[2], 32'h33);
      chk("rd40_b3", cap0[3], 32'h44);

      // Read starting at word 2 of the burst
      do_read(0, 32'h48, 0);
`ifdef SDRAM_MODEL_CRIT_WORD_FIRST_EN
      chk("rd48_b0", cap0[0], 32'h33);
      chk("rd48_b1", cap0[1], 32'h44);
      chk("rd48_b2", cap0[2], 32'h11);
      chk("rd48_b3", cap0[3], 32'h22);
`else
      chk("rd48_b0", cap0[0], 32'h11);
      chk("rd48_b1", cap0[1], 32'h22);
      chk("rd48_b2", cap0[2], 32'h33);
      chk("rd48_b3", cap0[3], 32'h44);
`endif

      // Byte enables
      for (int k = 0; k < 8; k++) begin wd[k] = 32'hFFFF_FFFF; wb[k] = 4'hF; end
      do_write(0, 32'h80, -1);
      for (int k = 0; k < 8; k++) begin wd[k] = 32'h0; wb[k] = 4'h0; end
      wb[0] = 4'h1;
      do_write(0, 32'h80, -1);
      do_read(0, 32'h80, 0);
      chk("be_b0", cap0[0], 32'hFFFF_FF00);
      chk("be_b1", cap0[1], 32'hFFFF_FFFF);

      // Old contents at 0x100, then a request injected mid-read
      for (int k = 0; k < 8; k++) begin wd[k] = 32'hA0A0_0000 + k; wb[k] = 4'hF; end
      do_write(0, 32'h100, -1);
      do_read(0, 32'h40, 7);
      chk("inj_err", 32'(err_o[0]), 32'h1);
      chk("inj_count", cap0.size(), 4);
      chk("inj_b3", cap0[3], 32'h44);

      // Reset during second write beat
      for (int k = 0; k < 8; k++) begin wd[k] = 32'h5555_0000 + k; wb[k] = 4'hF; end
      do_write(0, 32'h100, 1);
      chk("rst_err_clr", 32'(err_o[0]), 32'h0);
      do_read(0, 32'h100, 0);
      chk("rst_b0", cap0[0], 32'h5555_0000);
      chk("rst_b1", cap0[1], 32'hA0A0_0001);
      chk("rst_b3", cap0[3], 32'hA0A0_0003);

      // Simultaneous mr and mw in IDLE
      do_both(0, 32'h40);
      chk("both_err", 32'(err_o[0]), 32'h1);
      chk("both_busy", 32'(busy_o[0]), 32'h0);

      // Second configuration, back-to-back write then read
      for (int k = 0; k < 8; k++) begin wd[k] = 32'h0101_0101 * (k + 1); wb[k] = 4'hF; end
      do_write(1, 32'h200, -1);
      chk("b_wr_ack_gap", gr_cyc[1] - ref_edge[1], 1);
      do_read(1, 32'h200, 0);
      chk("b_rd_first_beat_lat", gr_cyc[1] - ref_edge[1], 2);
      chk("b_rd_count", cap1.size(), 8);
      chk("b_rd_b0", cap1[0], 32'h0101_0101);
      chk("b_rd_b7", cap1[7], 32'h0808_0808);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
